// File: rtl/sdr_pkg.sv
// Shared SDR datapath types and constants used by the RX stream consumers.
package sdr_pkg;

  localparam int unsigned SAMPLE_W     = 12;
  localparam int unsigned MAX_LOG2_DEC = 4;
  localparam int unsigned ACC_W        = SAMPLE_W + MAX_LOG2_DEC;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } iq_sample_t;

  // Limit a requested log2 decimation ratio to the supported maximum.
  function automatic logic [2:0] clamp_log2(input logic [2:0] k, input int unsigned max_log2);
    if (32'(k) > max_log2) return 3'(max_log2);
    return k;
  endfunction

endpackage

// File: rtl/iq_accum.sv
// Signed boxcar accumulator for one component: load/add/clear plus round-half-up dump.
module iq_accum #(
  parameter int unsigned DATA_W       = sdr_pkg::SAMPLE_W,
  parameter int unsigned MAX_LOG2_DEC = sdr_pkg::MAX_LOG2_DEC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     first,
  input  logic                     add,
  input  logic                     dump,
  input  logic [2:0]               k,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  localparam int unsigned ACC_W = DATA_W + MAX_LOG2_DEC;
  localparam int unsigned SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0]  acc;
  logic signed [SUM_W-1:0]  base;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  rnd;
  logic signed [DATA_W-1:0] dout_nxt;

  // Running sum including the current sample, and its rounded, scaled value.
  always_comb begin
    base = '0;
    rnd  = '0;
    if (!first) base = SUM_W'(acc);
    sum = base + SUM_W'(din);
    if (k != 3'd0) rnd = SUM_W'(1) << (k - 3'd1);
    dout_nxt = DATA_W'((sum + rnd) >>> k);
  end

  // Accumulator state; emptied after every dump or clear.
  always_ff @(posedge clk) begin
    if (rst || clear || dump) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum[ACC_W-1:0];
    end
  end

  // Output register; holds until the next dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (dump) begin
      dout <= dout_nxt;
    end
  end

endmodule

// File: rtl/rx_iq_decimator.sv
// Power-of-two I/Q decimator: boxcar average over 2^k samples with valid/ready on both sides.
module rx_iq_decimator #(
  parameter int unsigned DATA_W       = sdr_pkg::SAMPLE_W,
  parameter int unsigned MAX_LOG2_DEC = sdr_pkg::MAX_LOG2_DEC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               decim_log2,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic signed [DATA_W-1:0] in_data_q,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data_i,
  output logic signed [DATA_W-1:0] out_data_q,
  input  logic                     out_ready
);

  localparam int unsigned CNT_W = MAX_LOG2_DEC;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_idx;
  logic [2:0]       k_act;
  logic [2:0]       k_req;
  logic [2:0]       k_use;
  logic             first;
  logic             last;
  logic             accept;
  logic             acc_add;
  logic             dump;

  // Block control: the ratio in force is the fresh request at a block start, else the latched one.
  always_comb begin
    k_req    = sdr_pkg::clamp_log2(decim_log2, MAX_LOG2_DEC);
    first    = (cnt == '0);
    k_use    = first ? k_req : k_act;
    last_idx = CNT_W'(((CNT_W+1)'(1) << k_use) - (CNT_W+1)'(1));
    last     = (cnt == last_idx);
    in_ready = ~last | ~out_valid | out_ready;
    accept   = in_valid & in_ready & ~rst;
    dump     = accept & last & ~clear;
    acc_add  = accept & ~last & ~clear;
  end

  // Sample counter, ratio latch and output-valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      k_act     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (first) k_act <= k_req;
      if (clear || dump) begin
        cnt <= '0;
      end else if (acc_add) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (dump) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  iq_accum #(.DATA_W(DATA_W), .MAX_LOG2_DEC(MAX_LOG2_DEC)) u_accum_i (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .first (first),
    .add   (acc_add),
    .dump  (dump),
    .k     (k_use),
    .din   (in_data_i),
    .dout  (out_data_i)
  );

  iq_accum #(.DATA_W(DATA_W), .MAX_LOG2_DEC(MAX_LOG2_DEC)) u_accum_q (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .first (first),
    .add   (acc_add),
    .dump  (dump),
    .k     (k_use),
    .din   (in_data_q),
    .dout  (out_data_q)
  );

endmodule

// File: tb/tb_rx_iq_decimator.sv
// Directed bench for rx_iq_decimator with a reference-model scoreboard.
module tb_rx_iq_decimator;
  import sdr_pkg::iq_sample_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        decim_log2;
  logic              clear;
  logic              in_valid;
  logic signed [11:0] in_data_i;
  logic signed [11:0] in_data_q;
  logic              in_ready;
  logic              out_valid;
  logic signed [11:0] out_data_i;
  logic signed [11:0] out_data_q;
  logic              out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  int prev_t = 0;
  int last_t = 0;

  iq_sample_t exp_q[$];

  // Reference model state
  int mk   = 0;
  int mcnt = 0;
  int msi  = 0;
  int msq  = 0;

  rx_iq_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .decim_log2 (decim_log2),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data_i  (in_data_i),
    .in_data_q  (in_data_q),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data_i (out_data_i),
    .out_data_q (out_data_q),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_avg(input int s, input int k);
    if (k == 0) return s;
    return (s + (1 << (k - 1))) >>> k;
  endfunction

  function automatic int clamp_k(input logic [2:0] k);
    return (k > 3'd4) ? 4 : int'(k);
  endfunction

  task automatic model_reset();
    mcnt = 0; msi = 0; msq = 0;
  endtask

  // Present one sample (called at posedge+1), wait for in_ready, update the model on accept.
  task automatic send(input int si, input int sq);
    int w;
    iq_sample_t e;
    in_valid  = 1'b1;
    in_data_i = 12'(si);
    in_data_q = 12'(sq);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("send_timeout_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (mcnt == 0) mk = clamp_k(decim_log2);
    msi += si;
    msq += sq;
    mcnt++;
    if (mcnt == (1 << mk)) begin
      e.i = 12'(rnd_avg(msi, mk));
      e.q = 12'(rnd_avg(msq, mk));
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every handshaken output against the oldest expectation.
  always @(negedge clk) begin
    iq_sample_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed_i=%0d expected=none", out_data_i);
      end else begin
        e = exp_q.pop_front();
        chk("out_i", 32'(out_data_i), 32'(e.i));
        chk("out_q", 32'(out_data_q), 32'(e.q));
      end
      n_out++;
      prev_t = last_t;
      last_t = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; decim_log2 = 3'd0; clear = 1'b0; in_valid = 1'b0;
    in_data_i = '0; in_data_q = '0; out_ready = 1'b1;
    idle(2);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_i", 32'(out_data_i), 0);
    chk("rst_out_q", 32'(out_data_q), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    idle(2);

    // k=0 pass-through, one cycle latency
    send(5, -7);
    @(negedge clk);
    chk("k0_valid", 32'(out_valid), 1);
    chk("k0_i", 32'(out_data_i), 5);
    chk("k0_q", 32'(out_data_q), -7);
    chk("k0_in_ready", 32'(in_ready), 1);
    idle(1);
    send(2047, -2048);
    @(negedge clk);
    chk("k0_valid2", 32'(out_valid), 1);
    chk("k0_i2", 32'(out_data_i), 2047);
    chk("k0_q2", 32'(out_data_q), -2048);
    idle(1);

    // k=2 averaging with rounding
    decim_log2 = 3'd2;
    idle(2);
    n0 = n_out;
    send(100, -100); send(101, -101); send(102, -102); send(103, -103);
    @(negedge clk);
    chk("k2_avg_i", 32'(out_data_i), 102);
    idle(1);
    send(-1, 1); send(-2, 2); send(-2, 2); send(-2, 2);
    @(negedge clk);
    chk("k2_neg_i", 32'(out_data_i), -2);
    idle(2);
    chk("k2_out_count", n_out - n0, 2);

    // Requested ratio 7 clamps to 16; full-scale sums must not overflow
    decim_log2 = 3'd7;
    idle(2);
    for (int j = 0; j < 32; j++) send(2047, -2048);
    @(negedge clk);
    chk("k4_full_i", 32'(out_data_i), 2047);
    chk("k4_full_q", 32'(out_data_q), -2048);
    idle(2);
    chk("k4_period", last_t - prev_t, 16);

    // k=1 backpressure on the last sample of a block
    decim_log2 = 3'd1;
    idle(2);
    send(1, 1); send(3, 3);
    out_ready = 1'b0;
    send(10, 10);
    in_valid = 1'b1; in_data_i = 12'sd20; in_data_q = 12'sd20;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_i", 32'(out_data_i), 2);
    end
    in_valid = 1'b0;
    idle(1);
    out_ready = 1'b1;
    send(20, 20);
    @(negedge clk);
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_i", 32'(out_data_i), 15);
    idle(2);

    // clear discards a partial block, including a sample offered alongside it
    decim_log2 = 3'd2;
    idle(2);
    send(7, 7); send(9, 9);
    in_valid = 1'b1; in_data_i = 12'sd99; in_data_q = 12'sd99; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    decim_log2 = 3'd1;
    send(10, -10); send(20, -20);
    @(negedge clk);
    chk("clr_i", 32'(out_data_i), 15);
    chk("clr_q", 32'(out_data_q), -15);
    idle(2);

    // Reset mid-block with a pending output; sample offered during reset is ignored
    decim_log2 = 3'd2;
    idle(2);
    out_ready = 1'b0;
    send(1, 1); send(2, 2); send(3, 3); send(4, 4);
    send(50, 50); send(60, 60);
    rst = 1'b1; in_valid = 1'b1; in_data_i = 12'sd1000; in_data_q = 12'sd1000;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_i", 32'(out_data_i), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    idle(1);
    out_ready = 1'b1;
    idle(2);
    send(8, -8); send(9, -9); send(10, -10); send(11, -11);
    @(negedge clk);
    chk("mrst_avg_i", 32'(out_data_i), 10);
    chk("mrst_avg_q", 32'(out_data_q), -9);
    idle(4);

    chk("sb_drained", exp_q.size(), 0);
    chk("total_outputs", n_out, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
